// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding controller for the pipelined CPU. A shift-register
// scoreboard tracks the instructions that have left ID (stage 0 = EX up to
// stage DEPTH-1). From it the block derives:
//   - a load-use style stall for PC / IF/ID (a bubble goes into EX instead)
//   - forward-select codes for the two EX operand muxes
//   - a saturating count of stall cycles
//
// Ports:
//   clk          CPU clock
//   reset        synchronous, active-high; clears scoreboard and counter
//   id_valid     ID holds a real instruction
//   id_rs/id_rt  ID source register addresses
//   id_rs_used   source A is actually read
//   id_rt_used   source B is actually read
//   id_wr        ID instruction writes a register
//   id_dest      ID destination (RegDst already resolved)
//   id_is_load   ID instruction is a load
//   flush        kill the ID instruction (branch taken, jump, IRQ)
//   stall        hold PC and IF/ID, insert bubble into EX (combinational)
//   fwd_a_sel    EX operand A source: 0 = ID read value, k = result of stage k
//   fwd_b_sel    EX operand B source, same encoding
//   stall_cnt    saturating count of stall cycles
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int ZERO_REG   = 1,
  localparam int SW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SW-1:0]     fwd_a_sel,
  output logic [SW-1:0]     fwd_b_sel,
  output logic [31:0]       stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dest;
    logic [SW-1:0]     ready;   // first stage at which the result can be forwarded
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t            sb_r [DEPTH];
  entry_t            new_entry_s;
  logic              hit_s;
  logic              stall_s;
  logic [SW-1:0]     fwd_a_s;
  logic [SW-1:0]     fwd_b_s;
  logic [31:0]       stall_cnt_r;

  // A producer satisfies a consumer source; register 0 is optionally hardwired.
  function automatic logic producer_match(input entry_t e,
                                          input logic [REG_AW-1:0] src,
                                          input logic used);
    logic zero_dest;
    zero_dest = (ZERO_REG != 0) && (e.dest == {REG_AW{1'b0}});
    return e.valid && e.wr && used && (e.dest == src) && !zero_dest;
  endfunction

  // Build the scoreboard entry for the instruction currently in ID.
  always_comb begin
    new_entry_s         = entry_t'({ENTRY_W{1'b0}});
    new_entry_s.valid   = 1'b1;
    new_entry_s.wr      = id_wr;
    new_entry_s.dest    = id_dest;
    new_entry_s.ready   = id_is_load ? SW'(LOAD_READY) : SW'(ALU_READY);
    new_entry_s.rs      = id_rs;
    new_entry_s.rt      = id_rt;
    new_entry_s.rs_used = id_rs_used;
    new_entry_s.rt_used = id_rt_used;
  end

  // Stall when a producer at stage j would only reach stage j+1 by the time the
  // ID instruction is in EX, and stage j+1 is still too early for its result.
  always_comb begin
    hit_s = 1'b0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      hit_s = hit_s |
              ((producer_match(sb_r[j], id_rs, id_rs_used) |
                producer_match(sb_r[j], id_rt, id_rt_used)) &
               ((j + 1) < int'(sb_r[j].ready)));
    end
    stall_s = hit_s & id_valid & ~flush;
  end

  // Forward selects: walk from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_a_s = {SW{1'b0}};
    fwd_b_s = {SW{1'b0}};
    for (int k = DEPTH - 1; k >= 1; k--) begin
      fwd_a_s = (sb_r[0].valid && producer_match(sb_r[k], sb_r[0].rs, sb_r[0].rs_used))
                ? SW'(k) : fwd_a_s;
      fwd_b_s = (sb_r[0].valid && producer_match(sb_r[k], sb_r[0].rt, sb_r[0].rt_used))
                ? SW'(k) : fwd_b_s;
    end
  end

  // Scoreboard shift: entries age by one stage each cycle, entry 0 takes the
  // ID instruction or a bubble when it is stalled, flushed or not valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_r[k] <= entry_t'({ENTRY_W{1'b0}});
      end
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_r[k] <= sb_r[k-1];
      end
      if (id_valid && !flush && !stall_s) begin
        sb_r[0] <= new_entry_s;
      end else begin
        sb_r[0] <= entry_t'({ENTRY_W{1'b0}});
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall     = stall_s;
  assign fwd_a_sel = fwd_a_s;
  assign fwd_b_sel = fwd_b_s;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. Two instances: unit 0 uses the default
// configuration (DEPTH=3, LOAD_READY=2), unit 1 uses DEPTH=4, LOAD_READY=3.
// A timestamp-based model (each issued instruction remembers the cycle it
// entered EX; its stage is simply "now - issue cycle") predicts stall, forward
// selects and the stall counter every cycle; directed sequences add literal
// expectations taken from hand-worked pipeline diagrams.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, flush;
  logic [1:0][4:0] id_rs, id_rt, id_dest;

  logic        stall_a, stall_b;
  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic [31:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .ALU_READY(1), .LOAD_READY(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
    .id_rs_used(id_rs_used[0]), .id_rt_used(id_rt_used[0]), .id_wr(id_wr[0]),
    .id_dest(id_dest[0]), .id_is_load(id_is_load[0]), .flush(flush[0]),
    .stall(stall_a), .fwd_a_sel(fa_a), .fwd_b_sel(fb_a), .stall_cnt(cnt_a));

  hazard_scoreboard #(.REG_AW(5), .DEPTH(4), .ALU_READY(1), .LOAD_READY(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
    .id_rs_used(id_rs_used[1]), .id_rt_used(id_rt_used[1]), .id_wr(id_wr[1]),
    .id_dest(id_dest[1]), .id_is_load(id_is_load[1]), .flush(flush[1]),
    .stall(stall_b), .fwd_a_sel(fa_b), .fwd_b_sel(fb_b), .stall_cnt(cnt_b));

  // ---------------- model ----------------
  typedef struct {
    int         t;      // cycle in which the instruction sits in EX
    logic       wr;
    logic [4:0] dest;
    int         ready;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
  } inst_t;

  inst_t       q [2][$];
  logic [31:0] mcnt [2];
  int          n = 0;

  function automatic int dep(input int u);
    return (u == 0) ? 3 : 4;
  endfunction

  function automatic int ldr(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  function automatic bit hits(input inst_t p, input logic [4:0] src, input logic used);
    return p.wr && used && (p.dest == src) && (p.dest != 5'd0);
  endfunction

  function automatic void eval(input int u, output int es, output int ea, output int eb);
    int    best_a, best_b, age;
    bit    have_c;
    inst_t c;
    es = 0; best_a = 99; best_b = 99; have_c = 0;
    c = '{0, 1'b0, 5'd0, 0, 5'd0, 5'd0, 1'b0, 1'b0};
    for (int i = 0; i < q[u].size(); i++) begin
      if (n == q[u][i].t) begin
        c = q[u][i];
        have_c = 1;
      end
    end
    for (int i = 0; i < q[u].size(); i++) begin
      age = n - q[u][i].t;
      if (age <= dep(u) - 2 && age + 1 < q[u][i].ready &&
          (hits(q[u][i], id_rs[u], id_rs_used[u]) || hits(q[u][i], id_rt[u], id_rt_used[u])))
        es = 1;
      if (have_c && age >= 1 && age <= dep(u) - 1) begin
        if (hits(q[u][i], c.rs, c.rsu) && age < best_a) best_a = age;
        if (hits(q[u][i], c.rt, c.rtu) && age < best_b) best_b = age;
      end
    end
    if (!(id_valid[u] && !flush[u])) es = 0;
    ea = (best_a == 99) ? 0 : best_a;
    eb = (best_b == 99) ? 0 : best_b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  initial begin
    mcnt[0] = 32'd0;
    mcnt[1] = 32'd0;
  end

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    int es, ea, eb;
    inst_t ni;
    for (int u = 0; u < 2; u++) begin
      eval(u, es, ea, eb);
      chk($sformatf("u%0d_stall", u), {63'd0, (u == 0) ? stall_a : stall_b}, es);
      chk($sformatf("u%0d_fwd_a", u), {62'd0, (u == 0) ? fa_a : fa_b}, ea);
      chk($sformatf("u%0d_fwd_b", u), {62'd0, (u == 0) ? fb_a : fb_b}, eb);
      chk($sformatf("u%0d_cnt", u), {32'd0, (u == 0) ? cnt_a : cnt_b}, {32'd0, mcnt[u]});
      if (reset) begin
        q[u].delete();
        mcnt[u] = 32'd0;
      end else begin
        if (es != 0 && mcnt[u] != 32'hFFFF_FFFF) mcnt[u] = mcnt[u] + 32'd1;
        if (id_valid[u] && !flush[u] && es == 0) begin
          ni = '{n + 1, id_wr[u], id_dest[u], id_is_load[u] ? ldr(u) : 1,
                 id_rs[u], id_rt[u], id_rs_used[u], id_rt_used[u]};
          q[u].push_back(ni);
        end
        while (q[u].size() > 0 && (n + 1) - q[u][0].t >= dep(u)) void'(q[u].pop_front());
      end
    end
    n++;
  end

  // ---------------- stimulus ----------------
  task automatic set_id(input int u, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic wr, input logic [4:0] dest,
                        input logic ld, input logic fl);
    id_valid[u] = v; id_rs[u] = rs; id_rt[u] = rt; id_rs_used[u] = rsu; id_rt_used[u] = rtu;
    id_wr[u] = wr; id_dest[u] = dest; id_is_load[u] = ld; flush[u] = fl;
  endtask

  task automatic nop(input int u);
    set_id(u, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic lw9(input int u);
    set_id(u, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
  endtask

  task automatic sub9(input int u);   // sub $10,$9,$0
    set_id(u, 1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
  endtask

  task automatic edge_go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    nop(0); nop(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mid();
    chk("rst_stall", {63'd0, stall_a}, 64'd0);
    chk("rst_fwd_a", {62'd0, fa_a}, 64'd0);
    chk("rst_cnt", {32'd0, cnt_a}, 64'd0);

    // ALU -> ALU back to back: no stall, both operands forwarded from stage 1
    edge_go(); set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0); mid();
    edge_go(); set_id(0, 1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0); mid();
    chk("alu_stall", {63'd0, stall_a}, 64'd0);
    edge_go(); nop(0); mid();
    chk("alu_fwd_a", {62'd0, fa_a}, 64'd1);
    chk("alu_fwd_b", {62'd0, fb_a}, 64'd1);

    // load-use: exactly one stall cycle, then forward from stage 2
    edge_go(); lw9(0); mid();
    edge_go(); sub9(0); mid();
    chk("lu_stall1", {63'd0, stall_a}, 64'd1);
    edge_go(); mid();
    chk("lu_stall2", {63'd0, stall_a}, 64'd0);
    chk("lu_cnt", {32'd0, cnt_a}, 64'd1);
    edge_go(); nop(0); mid();
    chk("lu_fwd_a", {62'd0, fa_a}, 64'd2);
    chk("lu_fwd_b", {62'd0, fb_a}, 64'd0);

    // load, nop, use: no stall, forward from stage 2
    edge_go(); lw9(0); mid();
    edge_go(); nop(0); mid();
    edge_go(); set_id(0, 1'b1, 5'd9, 5'd5, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0); mid();
    chk("gap_stall", {63'd0, stall_a}, 64'd0);
    edge_go(); nop(0); mid();
    chk("gap_fwd_a", {62'd0, fa_a}, 64'd2);

    // $0 is never forwarded; two writers of $8 -> youngest wins
    edge_go(); set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); mid();
    edge_go(); set_id(0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0); mid();
    chk("zero_stall", {63'd0, stall_a}, 64'd0);
    edge_go(); set_id(0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0); mid();
    chk("zero_fwd_a", {62'd0, fa_a}, 64'd0);
    edge_go(); set_id(0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0); mid();
    edge_go(); set_id(0, 1'b1, 5'd8, 5'd13, 1'b1, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0); mid();
    edge_go(); nop(0); mid();
    chk("young_fwd_a", {62'd0, fa_a}, 64'd1);

    // flush in the would-be stall cycle
    edge_go(); lw9(0); mid();
    edge_go(); sub9(0); flush[0] = 1'b1; mid();
    chk("fl_stall", {63'd0, stall_a}, 64'd0);
    chk("fl_cnt", {32'd0, cnt_a}, 64'd1);
    edge_go(); nop(0); mid();
    chk("fl_fwd_a", {62'd0, fa_a}, 64'd0);
    chk("fl_cnt2", {32'd0, cnt_a}, 64'd1);

    // id_valid=0 with matching sources: no stall
    edge_go(); lw9(0); mid();
    edge_go(); sub9(0); id_valid[0] = 1'b0; mid();
    chk("inv_stall", {63'd0, stall_a}, 64'd0);

    // reset while stalled
    edge_go(); lw9(0); mid();
    edge_go(); sub9(0); mid();
    chk("rs_stall", {63'd0, stall_a}, 64'd1);
    reset = 1'b1;
    edge_go(); reset = 1'b0; nop(0); mid();
    chk("rs_stall0", {63'd0, stall_a}, 64'd0);
    chk("rs_fwd_a", {62'd0, fa_a}, 64'd0);
    chk("rs_fwd_b", {62'd0, fb_a}, 64'd0);
    chk("rs_cnt", {32'd0, cnt_a}, 64'd0);

    // DEPTH=4, LOAD_READY=3: two stall cycles, then forward from stage 3
    edge_go(); lw9(1); mid();
    edge_go(); sub9(1); mid();
    chk("d4_stall1", {63'd0, stall_b}, 64'd1);
    edge_go(); mid();
    chk("d4_stall2", {63'd0, stall_b}, 64'd1);
    edge_go(); mid();
    chk("d4_stall3", {63'd0, stall_b}, 64'd0);
    chk("d4_cnt", {32'd0, cnt_b}, 64'd2);
    edge_go(); nop(1); mid();
    chk("d4_fwd_a", {62'd0, fa_b}, 64'd3);

    edge_go(); lw9(1); mid();
    edge_go(); sub9(1); mid();
    chk("d4_rs_stall", {63'd0, stall_b}, 64'd1);
    reset = 1'b1;
    edge_go(); reset = 1'b0; nop(1); mid();
    chk("d4_rs_stall0", {63'd0, stall_b}, 64'd0);
    chk("d4_rs_fwd_a", {62'd0, fa_b}, 64'd0);
    chk("d4_rs_fwd_b", {62'd0, fb_b}, 64'd0);
    chk("d4_rs_cnt", {32'd0, cnt_b}, 64'd0);

    edge_go(); edge_go();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the pipelined CPU. It replaces the fixed two-source forwarding logic and the single-cycle load-use check with a shift-register scoreboard of in-flight instructions. Pipeline depth after ID, load latency and register-address width are all configurable. The block sits beside the ID/EX/MEM/WB stage registers: it drives the stall for IF/ID and the forward-select codes for the EX operand muxes, and it counts stall cycles.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, number of tracked stages after ID (stage 0 = EX ... stage DEPTH-1 = last stage before regfile write completes); legal range 2..8
ALU_READY, 1, first stage index at which a non-load result is forwardable
LOAD_READY, 2, first stage index at which load data is forwardable; must be >= ALU_READY and <= DEPTH-1
ZERO_REG, 1, when 1, destination 0 never matches and is never forwarded

Ports:
clk  in  1  CPU clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source A
id_rt  in  REG_AW  ID source B
id_rs_used  in  1  source A is actually read
id_rt_used  in  1  source B is actually read
id_wr  in  1  ID instruction writes a register
id_dest  in  REG_AW  ID destination, already RegDst-resolved
id_is_load  in  1  ID instruction is a load
flush  in  1  kill the ID instruction (branch taken, jump, IRQ)
stall  out  1  hold PC and IF/ID, insert bubble into EX
fwd_a_sel  out  $clog2(DEPTH)  EX operand A source: 0 = value read in ID, k = result of stage k
fwd_b_sel  out  $clog2(DEPTH)  EX operand B source, same encoding
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- State: DEPTH entries, each holding {valid, wr, dest, ready_stage, rs, rt, rs_used, rt_used}. ready_stage = LOAD_READY for loads, ALU_READY otherwise.
- Every cycle the entries shift: entry k+1 <= entry k. Entry DEPTH-1 is discarded. The regfile write-through is handled outside this block.
- Entry 0 loads the ID instruction when id_valid & !flush & !stall. Otherwise entry 0 loads a bubble (valid=0).
- A producer "matches" a source when all of these hold: valid, wr, dest == source, source used, and !(ZERO_REG && dest == 0).
- Stall (combinational): asserted when the ID instruction matches any producer j in 0..DEPTH-2 with j+1 < ready_stage of that producer. It is qualified by id_valid & !flush. Flush forces stall = 0.
- Defaults: DEPTH=3, ALU_READY=1, LOAD_READY=2. Load followed by an immediate consumer stalls exactly 1 cycle. ALU followed by a consumer never stalls.
- fwd_a_sel / fwd_b_sel (combinational from state only): compare the entry 0 rs/rt against entries 1..DEPTH-1 and select the smallest (youngest) matching index k. The result is 0 if there is no match or entry 0 is invalid. Readiness is guaranteed by the stall; the select does not check it.
- stall_cnt increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
- Reset: all entries invalid, stall_cnt=0, stall=0, fwd_a_sel=fwd_b_sel=0. This applies in the cycle after the reset edge; reset asserted mid-stall clears everything.
- Simultaneous events:
  - flush together with a would-be stall: no stall, bubble inserted, counter unchanged.
  - id_valid=0: no stall, bubble inserted.
  - Multiple matches: the youngest wins.
- Latency: stall and fwd are zero-cycle combinational outputs. The scoreboard updates on the clock edge.

Test Plan:
- add $8 then add $9,$8,$8 back-to-back -> stall never 1; next cycle fwd_a_sel=1, fwd_b_sel=1.
- lw $9 then sub $10,$9,$0 -> stall=1 for exactly 1 cycle, stall_cnt=1; when sub is in EX, fwd_a_sel=2.
- lw $9, nop, use $9 -> no stall; fwd_a_sel=2.
- write $0 then read $0 -> no stall, fwd_a_sel=0. Write $8 twice in successive cycles then read $8 -> fwd_a_sel=1 (youngest wins).
- Load-use pair with flush=1 in the stall cycle -> stall=0, stall_cnt unchanged, entry 0 bubble, next fwd_a_sel=0.
- DEPTH=4, LOAD_READY=3: load then immediate use -> 2 stall cycles, then fwd_a_sel=3. Assert reset during a stall -> next cycle all outputs 0.
